// File: rtl/microwave_ctrl_gen_if.sv
// microwave_ctrl_gen_if: keypad/button inputs and display/drive outputs of the microwave controller
interface microwave_ctrl_gen_if #(
  parameter int MIN_DIGITS = 1
);
  logic [9:0] key;
  logic startn;
  logic stopn;
  logic power_key;
  logic door_closed;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [4*MIN_DIGITS-1:0] mins;
  logic [3:0] power;
  logic mag_on;
  logic beep;
  modport master (
    output key, startn, stopn, power_key, door_closed,
    input sec_ones, sec_tens, mins, power, mag_on, beep
  );
  modport slave (
    input key, startn, stopn, power_key, door_closed,
    output sec_ones, sec_tens, mins, power, mag_on, beep
  );
endinterface

// File: rtl/microwave_ctrl_gen.sv
// microwave_ctrl_gen: keypad entry, duty-cycled magnetron gating and BCD MM:SS countdown
module microwave_ctrl_gen #(
  parameter int TICK_DIV = 50_000_000,
  parameter int MIN_DIGITS = 1,
  parameter int BEEP_SECS = 3
) (
  input logic clock,
  input logic clearn,
  microwave_ctrl_gen_if.slave io
);
  localparam int TW = 4*MIN_DIGITS + 8;
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BEEP_SECS + 1);
  typedef enum logic [2:0] {IDLE, ENTRY, COOK, PAUSE, DONE} state_t;
  state_t state, state_d;
  logic [TW-1:0] tv, tv_d, tv_key, tv_dec;
  logic [4*MIN_DIGITS-1:0] mdec;
  logic [3:0] pwr, pwr_d, ph, ph_d, dig;
  logic [PW-1:0] pre, pre_d;
  logic [BW-1:0] bc, bc_d;
  logic [9:0] key_q;
  logic startn_q, stopn_q, pk_q;
  logic key_ev, start_ev, stop_ev, pwr_ev, run, tick, can_start;
  assign key_ev = key_q == '0 && $onehot(io.key);
  assign start_ev = !io.startn && startn_q;
  assign stop_ev = !io.stopn && stopn_q;
  assign pwr_ev = io.power_key && !pk_q;
  assign run = state == COOK || state == DONE;
  assign tick = run && pre == PW'(TICK_DIV - 1);
  assign can_start = start_ev && io.door_closed && tv != '0;
  always_comb begin
    dig = '0;
    for (int i = 0; i < 10; i++) if (io.key[i]) dig = 4'(i);
  end
  // minutes borrow chain: a zero nibble becomes 9 and passes the borrow upward
  always_comb begin : dec
    logic b;
    b = 1'b1;
    mdec = '0;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      mdec[4*i+:4] = !b ? tv[8+4*i+:4] : tv[8+4*i+:4] == 4'd0 ? 4'd9 : tv[8+4*i+:4] - 4'd1;
      b = b && tv[8+4*i+:4] == 4'd0;
    end
  end
  assign tv_key = {tv[TW-5:0], dig};
  assign tv_dec = tv[3:0] != 4'd0 ? {tv[TW-1:4], tv[3:0] - 4'd1} :
                  tv[7:4] != 4'd0 ? {tv[TW-1:8], tv[7:4] - 4'd1, 4'd9} : {mdec, 8'h59};
  always_comb begin
    state_d = state;
    tv_d = tv;
    pwr_d = pwr;
    ph_d = ph;
    bc_d = bc;
    pre_d = run ? (tick ? '0 : pre + 1'b1) : pre;
    case (state)
      IDLE, ENTRY: begin
        if (stop_ev) begin
          state_d = IDLE;
          tv_d = '0;
          pwr_d = 4'd10;
        end else if (can_start) begin
          state_d = COOK;
          pre_d = '0;
          ph_d = '0;
        end else if (pwr_ev) pwr_d = pwr == 4'd1 ? 4'd10 : pwr - 4'd1;
        else if (key_ev) begin
          state_d = ENTRY;
          tv_d = tv_key;
        end
      end
      COOK: begin
        if (!io.door_closed || stop_ev) state_d = PAUSE;
        else if (tick) begin
          tv_d = tv_dec;
          ph_d = ph == 4'd9 ? '0 : ph + 4'd1;
          if (tv_dec == '0) begin
            state_d = DONE;
            pre_d = '0;
            bc_d = '0;
          end
        end
      end
      PAUSE: begin
        if (stop_ev) begin
          state_d = IDLE;
          tv_d = '0;
          pwr_d = 4'd10;
        end else if (can_start) begin
          state_d = COOK;
          pre_d = '0;
          ph_d = '0;
        end
      end
      DONE: begin
        if (key_ev || start_ev || stop_ev) state_d = IDLE;
        else if (tick) begin
          bc_d = bc + 1'b1;
          if (bc == BW'(BEEP_SECS - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge clearn)
    if (!clearn) begin
      state <= IDLE;
      tv <= '0;
      pwr <= 4'd10;
      ph <= '0;
      pre <= '0;
      bc <= '0;
      key_q <= '0;
      startn_q <= 1'b1;
      stopn_q <= 1'b1;
      pk_q <= 1'b0;
    end else begin
      state <= state_d;
      tv <= tv_d;
      pwr <= pwr_d;
      ph <= ph_d;
      pre <= pre_d;
      bc <= bc_d;
      key_q <= io.key;
      startn_q <= io.startn;
      stopn_q <= io.stopn;
      pk_q <= io.power_key;
    end
  assign io.sec_ones = tv[3:0];
  assign io.sec_tens = tv[7:4];
  assign io.mins = tv[TW-1:8];
  assign io.power = pwr;
  assign io.beep = state == DONE;
  assign io.mag_on = state == COOK && io.door_closed && ph < pwr;
endmodule

// File: doc/microwave_ctrl_gen.md
# microwave_ctrl_gen

Parametrised microwave-oven controller that merges keypad entry, magnetron gating and the MM:SS countdown into one sequential block. It adds a configurable number of minute digits, ten power levels with duty-cycled magnetron drive, pause/resume, and an end-of-cook beep. It sits between the keypad/button inputs and the per-digit seven-segment decoders at the top level. Its BCD outputs feed the decoders unchanged.

## Interface
- TICK_DIV, 50_000_000, clock cycles per 1 s tick (≥2)
- MIN_DIGITS, 1, BCD minute digits (1 or 2); max entry 9:99 or 99:99
- BEEP_SECS, 3, ticks the beep stays high in DONE (≥1)

- clock  in  1  system clock; all logic on rising edge
- clearn  in  1  asynchronous, active-low reset
- key  in  10  digit keys, key[i] = digit i; level, synchronous to clock
- startn  in  1  start button, active-low
- stopn  in  1  stop/clear button, active-low
- power_key  in  1  power-level button, active-high
- door_closed  in  1  1 = door closed
- sec_ones  out  4  BCD seconds units
- sec_tens  out  4  BCD seconds tens (0–9 allowed)
- mins  out  4*MIN_DIGITS  BCD minutes, most significant digit in the top nibble
- power  out  4  power level, binary 1–10
- mag_on  out  1  magnetron enable
- beep  out  1  end-of-cook beeper

## Operation
- States: IDLE, ENTRY, COOK, PAUSE, DONE. Reset: IDLE, all digits 0, power=10, mag_on=0, beep=0, prescaler=0, phase=0.
- Events are registered edges of the inputs: key press = key≠0 and previous key=0. Start = startn falling. Stop = stopn falling. Power = power_key rising.
- A key press with more than one bit set is ignored.
- Key press in IDLE/ENTRY shifts the digit in from the right: sec_ones←digit, sec_tens←old sec_ones, lowest min nibble←old sec_tens, and each higher min nibble←the nibble below it. The top min nibble is discarded. State→ENTRY.
- Key presses in COOK/PAUSE/DONE are ignored, except in DONE (see below).
- Power in IDLE/ENTRY: power decrements 10→9→…→1→10. Power is ignored in all other states.
- Start in IDLE/ENTRY/PAUSE with door_closed=1 and time≠0 → COOK. Entering COOK clears the prescaler and phase.
- Start with the door open or time=0 is ignored.
- Stop in COOK → PAUSE; time is held.
- Stop in PAUSE/ENTRY/IDLE → IDLE with all digits 0 and power=10.
- door_closed=0 in COOK → PAUSE on the next edge.
- Countdown, once per tick in COOK: if sec_ones>0, decrement it.
  - Else if sec_tens>0: sec_ones=9 and sec_tens decrements.
  - Else: sec_ones=9, sec_tens=5, and the minutes decrement as a multi-digit BCD value with borrow.
  - Entry 0:99 therefore lasts 99 ticks and 1:00 lasts 60 ticks.
- Tick on which the time becomes 0:00 → DONE. Entering DONE sets beep=1 and clears the prescaler.
- DONE: beep stays 1 for BEEP_SECS ticks, then → IDLE with beep=0.
- Any key, start or stop event in DONE → IDLE immediately with beep=0. Power is kept.
- Duty cycle: phase counts 0..9 and advances on each COOK tick (wraps 9→0). mag_on = (state==COOK) & door_closed & (phase < power). Power 10 gives continuous drive.
- mag_on is combinational on door_closed, so it drops in the same cycle the door opens.
- The prescaler runs only in COOK and DONE and holds in all other states.

## Timing
- Every event takes effect at the clock edge that first samples the asserted input level. Outputs are visible one cycle later.
- Tick: the prescaler reaches TICK_DIV-1 and wraps. The first tick occurs TICK_DIV cycles after entry to COOK.
- PAUSE→COOK restarts the prescaler. Partial seconds are discarded.
- Simultaneous events are resolved by priority: clearn > door open > stop > start > power > key.
- Asserting clearn at any time, including mid-cook or mid-beep, immediately forces the reset values.

## Test plan
All scenarios use TICK_DIV=4 and BEEP_SECS=3.
- Reset, then keys 1,3,0 → mins=1, sec_tens=3, sec_ones=0, state ENTRY, mag_on=0.
- Enter 0:99 at power 10, then start → mag_on high continuously. After 99 ticks the time is 0:00, beep=1 for 12 cycles, then IDLE.
- Enter 1:00, then start → after 1 tick the display reads 0:59 (borrow path).
- MIN_DIGITS=2: enter 10:00 → after 1 tick the display reads 09:59.
- Five power presses (power=5), enter 0:20, start → mag_on high for 5 ticks, low for 5, repeating.
- During COOK, drop door_closed → mag_on=0 the same cycle and the state becomes PAUSE. Restart with door closed → countdown resumes from the held time.
- Stop twice → PAUSE, then IDLE with time 0:00 and power 10.
- Start with time=0 → state stays IDLE.
